// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode encodings, arbiter FSM state type and latency helper
//            shared by the ALU arbiter and its sub-modules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_MUL    = 4'b0000;
  localparam logic [3:0] ALU_DIV    = 4'b0001;
  localparam logic [3:0] ALU_OR     = 4'b0010;
  localparam logic [3:0] ALU_OR_ALT = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_NOP    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // MUL and DIV are the only opcodes that need the multi-cycle operand hold
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first asserted request found
//            searching upward from last_grant_i + 1 with wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic            gnt_valid_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic [NREQ-1:0] gnt_onehot_o
);

  // Walk the search order backwards so the nearest requester after
  // last_grant_i is the final (winning) assignment.
  always_comb begin
    gnt_valid_o  = 1'b0;
    gnt_idx_o    = '0;
    gnt_onehot_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[(int'(last_grant_i) + k) % NREQ]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'((int'(last_grant_i) + k) % NREQ);
      end
    end
    if (gnt_valid_o) begin
      gnt_onehot_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one external ALU between NREQ requesters,
//            with registered operands and MUL/DIV multi-cycle sequencing.
//            Optional macro ALU_ARB_DIVZERO_EN: DIV by zero finishes in one
//            EXEC cycle returning all-ones with a clear Zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DW         = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_op,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_result,
  output logic               rsp_zero,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [3:0]         alu_op,
  input  logic [DW-1:0]      alu_result,
  input  logic               alu_zero
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] MULDIV_CNT = CW'(MULDIV_LAT - 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [DW-1:0]   result_q, result_d;
  logic            zero_q, zero_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [DW-1:0]   sel_a, sel_b;
  logic [3:0]      sel_op;
  logic [CW-1:0]   sel_cnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .gnt_valid_o  (pick_valid),
    .gnt_idx_o    (pick_idx),
    .gnt_onehot_o (pick_onehot)
  );

  assign sel_a  = req_a[int'(pick_idx)*DW +: DW];
  assign sel_b  = req_b[int'(pick_idx)*DW +: DW];
  assign sel_op = req_op[int'(pick_idx)*4 +: 4];

  // EXEC countdown preload: the ALU sees stable operands for cnt+1 cycles
  always_comb begin
    sel_cnt = is_muldiv(sel_op) ? MULDIV_CNT : '0;
`ifdef ALU_ARB_DIVZERO_EN
    if ((sel_op == ALU_DIV) && (sel_b == '0)) begin
      sel_cnt = '0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    req_ready = '0;
    rsp_valid = '0;

    case (state_q)
      IDLE: begin
        req_ready = pick_onehot;
        if (pick_valid) begin
          grant_d  = pick_idx;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          cnt_d    = sel_cnt;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          zero_d   = alu_zero;
`ifdef ALU_ARB_DIVZERO_EN
          if ((alu_op_q == ALU_DIV) && (alu_b_q == '0)) begin
            result_d = '1;
            zero_d   = 1'b0;
          end
`endif
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IW'(NREQ - 1);
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_NOP;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter: directed scenarios with
//            literal expectations, then randomized traffic against a
//            transaction-level timing model. Honours ALU_ARB_DIVZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int NREQ       = 2;
  localparam int DW         = 32;
  localparam int MULDIV_LAT = 4;
`ifdef ALU_ARB_DIVZERO_EN
  localparam int DZ_L = 1;
`else
  localparam int DZ_L = MULDIV_LAT;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]    p_valid;
  logic [DW-1:0]      p_a [NREQ];
  logic [DW-1:0]      p_b [NREQ];
  logic [3:0]         p_op [NREQ];
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [NREQ*4-1:0]  req_op;
  logic [DW-1:0]      rsp_result, alu_a, alu_b, alu_result;
  logic               rsp_zero, alu_zero;
  logic [3:0]         alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .MULDIV_LAT(MULDIV_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_valid = p_valid;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = p_a[i];
      req_b[i*DW +: DW] = p_b[i];
      req_op[i*4 +: 4]  = p_op[i];
    end
  end

  // Reference ALU: returns {zero, result}
  function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [3:0] op);
    logic [DW-1:0] r;
    case (op)
      4'd0:       r = a * b;
      4'd1:       r = (b == 0) ? '0 : a / b;
      4'd2, 4'd3: r = a | b;
      4'd4:       r = a ^ b;
      4'd5:       r = a << b[4:0];
      4'd6:       r = a >> b[4:0];
      4'd7:       r = $signed(a) >>> b[4:0];
      4'd8:       r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:       r = (a < b) ? 1 : 0;
      default:    r = '0;
    endcase
    return {(r == 0), r};
  endfunction

  always_comb {alu_zero, alu_result} = ref_alu(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Transaction-level model: a grant at cycle N yields a response from
  // cycle N+L+1 until the granted requester accepts it.
  bit              m_init = 0;
  bit              m_busy;
  int              m_last, m_grant;
  longint          m_rsp_start;
  logic [DW-1:0]   m_alu_a, m_alu_b, m_res;
  logic [3:0]      m_alu_op;
  logic            m_zero;
  logic [NREQ-1:0] acc;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready, exp_rv;
    int w, lat;
    w = -1;
    if (m_init) begin
      exp_ready = '0;
      exp_rv    = '0;
      if (!m_busy) begin
        w = pick(p_valid, m_last);
        if (w >= 0) exp_ready[w] = 1'b1;
      end else if (cyc >= m_rsp_start) begin
        exp_rv[m_grant] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("alu_a", 64'(alu_a), 64'(m_alu_a));
      chk("alu_b", 64'(alu_b), 64'(m_alu_b));
      chk("alu_op", 64'(alu_op), 64'(m_alu_op));
      if (exp_rv != 0) begin
        chk("rsp_result", 64'(rsp_result), 64'(m_res));
        chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      end
    end
    if (rst) begin
      m_init   = 1;
      m_busy   = 0;
      m_last   = NREQ - 1;
      m_alu_a  = '0;
      m_alu_b  = '0;
      m_alu_op = 4'hF;
    end else if (m_init) begin
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy   = 1;
          m_grant  = w;
          m_alu_a  = p_a[w];
          m_alu_b  = p_b[w];
          m_alu_op = p_op[w];
          {m_zero, m_res} = ref_alu(p_a[w], p_b[w], p_op[w]);
          lat = (p_op[w] <= 4'd1) ? MULDIV_LAT : 1;
`ifdef ALU_ARB_DIVZERO_EN
          if (p_op[w] == 4'd1 && p_b[w] == 0) begin
            lat    = 1;
            m_res  = '1;
            m_zero = 1'b0;
          end
`endif
          m_rsp_start = cyc + lat + 1;
          acc[w] = 1'b1;
        end
      end else if (cyc >= m_rsp_start && rsp_ready[m_grant]) begin
        m_busy = 0;
        m_last = m_grant;
      end
    end
    cyc++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] op);
    p_valid[r] = 1'b1;
    p_a[r]     = a;
    p_b[r]     = b;
    p_op[r]    = op;
  endtask

  initial begin
    logic [NREQ-1:0] seen [$];
    rst       = 1'b1;
    p_valid   = '0;
    rsp_ready = '0;
    acc       = '0;
    for (int i = 0; i < NREQ; i++) begin
      p_a[i] = '0; p_b[i] = '0; p_op[i] = 4'hF;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_result", 64'(rsp_result), 64'h0);
    chk("reset_zero", 64'(rsp_zero), 64'h0);
    chk("reset_alu_a", 64'(alu_a), 64'h0);
    chk("reset_alu_b", 64'(alu_b), 64'h0);
    chk("reset_alu_op", 64'(alu_op), 64'hF);

    // XOR from requester 0: response two cycles after the grant
    next();
    set_req(0, 32'hF0F0_0000, 32'h0F0F_0000, 4'b0100);
    rsp_ready = 2'b11;
    smp(); chk("t1_ready", 64'(req_ready), 64'h1);
    next(); p_valid[0] = 1'b0;
    smp(); chk("t1_wait_valid", 64'(rsp_valid), 64'h0);
    next();
    smp(); chk("t1_valid", 64'(rsp_valid), 64'h1);
    chk("t1_result", 64'(rsp_result), 64'hFFFF_0000);
    chk("t1_zero", 64'(rsp_zero), 64'h0);

    // MUL from requester 1: operands held for MULDIV_LAT cycles
    next();
    set_req(1, 32'd3, 32'd5, 4'b0000);
    smp(); chk("t2_ready", 64'(req_ready), 64'h2);
    for (int k = 1; k <= MULDIV_LAT; k++) begin
      next();
      if (k == 1) p_valid[1] = 1'b0;
      smp();
      chk("t2_hold_a", 64'(alu_a), 64'd3);
      chk("t2_hold_b", 64'(alu_b), 64'd5);
      chk("t2_hold_op", 64'(alu_op), 64'd0);
      chk("t2_no_valid", 64'(rsp_valid), 64'h0);
    end
    next();
    smp(); chk("t2_valid", 64'(rsp_valid), 64'h2);
    chk("t2_result", 64'(rsp_result), 64'd15);

    // DIV by zero from requester 0
    next();
    set_req(0, 32'd7, 32'd0, 4'b0001);
    smp(); chk("t5_ready", 64'(req_ready), 64'h1);
    for (int k = 1; k <= DZ_L; k++) begin
      next();
      if (k == 1) p_valid[0] = 1'b0;
      smp(); chk("t5_no_valid", 64'(rsp_valid), 64'h0);
    end
    next();
    smp(); chk("t5_valid", 64'(rsp_valid), 64'h1);
`ifdef ALU_ARB_DIVZERO_EN
    chk("t5_result", 64'(rsp_result), 64'hFFFF_FFFF);
    chk("t5_zero", 64'(rsp_zero), 64'h0);
`else
    chk("t5_result", 64'(rsp_result), 64'h0);
    chk("t5_zero", 64'(rsp_zero), 64'h1);
`endif

    // Response back-pressure for 10 cycles while requester 0 waits
    next();
    set_req(1, 32'h0000_00F0, 32'h0000_0F00, 4'b0010);
    rsp_ready = 2'b00;
    smp(); chk("t4_ready", 64'(req_ready), 64'h2);
    next();
    p_valid[1] = 1'b0;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'b1000);
    smp(); chk("t4_exec_ready", 64'(req_ready), 64'h0);
    for (int k = 0; k < 10; k++) begin
      next(); smp();
      chk("t4_hold_valid", 64'(rsp_valid), 64'h2);
      chk("t4_hold_result", 64'(rsp_result), 64'h0FF0);
      chk("t4_hold_ready", 64'(req_ready), 64'h0);
    end
    next(); rsp_ready = 2'b10;
    smp(); chk("t4_release_valid", 64'(rsp_valid), 64'h2);
    next();
    smp(); chk("t4_idle_ready", 64'(req_ready), 64'h1);
    chk("t4_idle_valid", 64'(rsp_valid), 64'h0);
    next(); p_valid[0] = 1'b0; rsp_ready = 2'b11;
    next();
    smp(); chk("t4_slt_valid", 64'(rsp_valid), 64'h1);
    chk("t4_slt_result", 64'(rsp_result), 64'h1);

    // Both requesters continuously valid: grants alternate starting at 1
    next();
    set_req(0, 32'h1234_5678, 32'h1111_1111, 4'b0100);
    set_req(1, 32'hAAAA_0000, 32'h0000_5555, 4'b0100);
    for (int k = 0; k < 12; k++) begin
      smp();
      chk("t3_onehot", 64'(req_ready & (req_ready - 1'b1)), 64'h0);
      if (req_ready != 0) seen.push_back(req_ready);
      next();
    end
    p_valid = '0;
    chk("t3_grant_count", 64'(seen.size()), 64'd4);
    if (seen.size() == 4) begin
      chk("t3_grant0", 64'(seen[0]), 64'h2);
      chk("t3_grant1", 64'(seen[1]), 64'h1);
      chk("t3_grant2", 64'(seen[2]), 64'h2);
      chk("t3_grant3", 64'(seen[3]), 64'h1);
    end

    // Reset during MUL EXEC: no response, requester 0 wins afterwards
    next();
    set_req(1, 32'd6, 32'd7, 4'b0000);
    smp(); chk("t6_ready", 64'(req_ready), 64'h2);
    next(); p_valid[1] = 1'b0;
    next(); rst = 1'b1;
    smp(); chk("t6_no_valid", 64'(rsp_valid), 64'h0);
    next();
    rst = 1'b0;
    set_req(0, 32'h0000_FFFF, 32'h0000_00FF, 4'b0100);
    set_req(1, 32'd9, 32'd9, 4'b0100);
    smp(); chk("t6_post_ready", 64'(req_ready), 64'h1);
    chk("t6_post_op", 64'(alu_op), 64'hF);
    chk("t6_post_valid", 64'(rsp_valid), 64'h0);
    next(); p_valid = '0;
    repeat (4) next();

    // Randomized traffic checked by the model process
    acc = '0;
    for (int c = 0; c < 4000; c++) begin
      next();
      rst = ($urandom_range(0, 299) == 0);
      rsp_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          acc[i]     = 1'b0;
          p_valid[i] = 1'b0;
        end
        if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  4'($urandom_range(0, 15)));
        end
      end
    end
    rst = 1'b0;
    smp();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
